// File: rtl/usb_bus_master_if.sv
// Signal bundle between the test sequencer and the USB register-bus initiator,
// including the parallel bus pins and a debug view of the FSM state.
`timescale 1ns/1ps
interface usb_bus_master_if #(
    parameter int pADDR_WIDTH   = 20,
    parameter int pBYTECNT_SIZE = 7
);
    logic                     cmd_valid;
    logic                     cmd_ready;
    logic                     cmd_write;
    logic [pADDR_WIDTH-1:0]   cmd_addr;
    logic [pBYTECNT_SIZE-1:0] cmd_len;
    logic [7:0]               wdata;
    logic                     wdata_valid;
    logic                     wdata_ready;
    logic [7:0]               rdata;
    logic                     rdata_valid;
    logic                     done;
    logic [pADDR_WIDTH-1:0]   usb_addr;
    logic [7:0]               usb_dout;
    logic [7:0]               usb_din;
    logic                     usb_drive_en;
    logic                     usb_cen;
    logic                     usb_rdn;
    logic                     usb_wrn;
    logic [2:0]               dbg_state;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_len, wdata, wdata_valid, usb_din,
        output cmd_ready, wdata_ready, rdata, rdata_valid, done,
        output usb_addr, usb_dout, usb_drive_en, usb_cen, usb_rdn, usb_wrn, dbg_state
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_len, wdata, wdata_valid, usb_din,
        input  cmd_ready, wdata_ready, rdata, rdata_valid, done,
        input  usb_addr, usb_dout, usb_drive_en, usb_cen, usb_rdn, usb_wrn, dbg_state
    );
endinterface

// File: rtl/usb_bus_master.sv
// Bus initiator for the parallel USB register bus: turns command/stream requests
// into timed nCE/nRD/nWR cycles with auto-incrementing bursts. All outputs registered.
`timescale 1ns/1ps
module usb_bus_master #(
    parameter int pADDR_WIDTH    = 20,
    parameter int pBYTECNT_SIZE  = 7,
    parameter int pSETUP_CYCLES  = 1,
    parameter int pSTROBE_CYCLES = 2,
    parameter int pHOLD_CYCLES   = 1
) (
    input  logic             clk,
    input  logic             reset,
    usb_bus_master_if.master bus
);
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WDATA  = 3'd1,
        SETUP  = 3'd2,
        STROBE = 3'd3,
        HOLD   = 3'd4
    } state_e;

    localparam logic [3:0] SETUP_LAST  = 4'(pSETUP_CYCLES - 1);
    localparam logic [3:0] STROBE_LAST = 4'(pSTROBE_CYCLES - 1);
    localparam logic [3:0] HOLD_LAST   = 4'(pHOLD_CYCLES - 1);

    state_e                   state_q, state_d;
    logic [3:0]               cnt_q, cnt_d;
    logic [pBYTECNT_SIZE-1:0] rem_q, rem_d;
    logic                     write_q, write_d;
    logic [pADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [7:0]               dout_q, dout_d;
    logic [7:0]               rdata_q, rdata_d;
    logic                     rdata_valid_q, rdata_valid_d;
    logic                     done_q, done_d;
    logic                     cen_q, cen_d;
    logic                     rdn_q, rdn_d;
    logic                     wrn_q, wrn_d;
    logic                     drive_en_q, drive_en_d;
    logic                     cmd_ready_q, cmd_ready_d;
    logic                     wdata_ready_q, wdata_ready_d;

    // Handshakes: a transfer happens on a rising edge where valid and ready are both
    // high; ready is a registered function of the state and never depends on valid.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        rem_d         = rem_q;
        write_d       = write_q;
        addr_d        = addr_q;
        dout_d        = dout_q;
        rdata_d       = rdata_q;
        rdata_valid_d = 1'b0;
        done_d        = 1'b0;
        cen_d         = cen_q;
        rdn_d         = rdn_q;
        wrn_d         = wrn_q;
        drive_en_d    = drive_en_q;

        case (state_q)
            IDLE: begin
                if (bus.cmd_valid && cmd_ready_q) begin
                    addr_d  = bus.cmd_addr;
                    write_d = bus.cmd_write;
                    rem_d   = bus.cmd_len;
                    cen_d   = 1'b0;
                    cnt_d   = 4'd0;
                    state_d = bus.cmd_write ? WDATA : SETUP;
                end
            end
            WDATA: begin
                if (bus.wdata_valid && wdata_ready_q) begin
                    dout_d     = bus.wdata;
                    drive_en_d = 1'b1;
                    cnt_d      = 4'd0;
                    state_d    = SETUP;
                end
            end
            SETUP: begin
                if (cnt_q == SETUP_LAST) begin
                    cnt_d   = 4'd0;
                    rdn_d   = write_q;
                    wrn_d   = !write_q;
                    state_d = STROBE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            STROBE: begin
                if (cnt_q == STROBE_LAST) begin
                    cnt_d   = 4'd0;
                    rdn_d   = 1'b1;
                    wrn_d   = 1'b1;
                    state_d = HOLD;
                    // Sample the bus while nRD is still low; the byte is presented in HOLD.
                    if (!write_q) begin
                        rdata_d       = bus.usb_din;
                        rdata_valid_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    cnt_d = 4'd0;
                    if (rem_q != '0) begin
                        addr_d = addr_q + pADDR_WIDTH'(1);
                        rem_d  = rem_q - pBYTECNT_SIZE'(1);
                        if (write_q) begin
                            drive_en_d = 1'b0;
                            state_d    = WDATA;
                        end else begin
                            state_d = SETUP;
                        end
                    end else begin
                        cen_d      = 1'b1;
                        drive_en_d = 1'b0;
                        done_d     = 1'b1;
                        state_d    = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        cmd_ready_d   = (state_d == IDLE);
        wdata_ready_d = (state_d == WDATA);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            cnt_q         <= 4'd0;
            rem_q         <= '0;
            write_q       <= 1'b0;
            addr_q        <= '0;
            dout_q        <= 8'h00;
            rdata_q       <= 8'h00;
            rdata_valid_q <= 1'b0;
            done_q        <= 1'b0;
            cen_q         <= 1'b1;
            rdn_q         <= 1'b1;
            wrn_q         <= 1'b1;
            drive_en_q    <= 1'b0;
            cmd_ready_q   <= 1'b1;
            wdata_ready_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            rem_q         <= rem_d;
            write_q       <= write_d;
            addr_q        <= addr_d;
            dout_q        <= dout_d;
            rdata_q       <= rdata_d;
            rdata_valid_q <= rdata_valid_d;
            done_q        <= done_d;
            cen_q         <= cen_d;
            rdn_q         <= rdn_d;
            wrn_q         <= wrn_d;
            drive_en_q    <= drive_en_d;
            cmd_ready_q   <= cmd_ready_d;
            wdata_ready_q <= wdata_ready_d;
        end
    end

    assign bus.cmd_ready    = cmd_ready_q;
    assign bus.wdata_ready  = wdata_ready_q;
    assign bus.rdata        = rdata_q;
    assign bus.rdata_valid  = rdata_valid_q;
    assign bus.done         = done_q;
    assign bus.usb_addr     = addr_q;
    assign bus.usb_dout     = dout_q;
    assign bus.usb_drive_en = drive_en_q;
    assign bus.usb_cen      = cen_q;
    assign bus.usb_rdn      = rdn_q;
    assign bus.usb_wrn      = wrn_q;
    assign bus.dbg_state    = state_q;
endmodule

// File: tb/tb_usb_bus_master.sv
// Bench for usb_bus_master: default-timing instance driven from a vector table,
// plus a slow-timing instance and a reset-mid-strobe sequence.
`timescale 1ns/1ps
module tb_usb_bus_master;
    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    usb_bus_master_if #(.pADDR_WIDTH(20), .pBYTECNT_SIZE(7)) ifa ();
    usb_bus_master_if #(.pADDR_WIDTH(20), .pBYTECNT_SIZE(7)) ifb ();

    usb_bus_master #(
        .pADDR_WIDTH(20), .pBYTECNT_SIZE(7),
        .pSETUP_CYCLES(1), .pSTROBE_CYCLES(2), .pHOLD_CYCLES(1)
    ) dut_a (.clk(clk), .reset(reset), .bus(ifa));

    usb_bus_master #(
        .pADDR_WIDTH(20), .pBYTECNT_SIZE(7),
        .pSETUP_CYCLES(3), .pSTROBE_CYCLES(1), .pHOLD_CYCLES(2)
    ) dut_b (.clk(clk), .reset(reset), .bus(ifb));

    // Bus model: data is only valid while nRD is low, so late/early capture is visible.
    assign ifa.usb_din = ifa.usb_rdn ? 8'hEE : (ifa.usb_addr[7:0] ^ 8'h5A);
    assign ifb.usb_din = ifb.usb_rdn ? 8'hEE : (ifb.usb_addr[7:0] ^ 8'h5A);

    int total  = 0;
    int passed = 0;
    logic [7:0] exp_q[$];

    typedef struct {
        logic        wr;
        logic [19:0] addr;
        logic [6:0]  len;
        int          stall;
        logic [7:0]  wbase;
        int          exp_bytes;
        logic [19:0] exp_last_addr;
        logic [7:0]  exp_first;
        logic [7:0]  exp_last;
        int          exp_cycles;
        int          exp_ready;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic idle_inputs();
        ifa.cmd_valid = 1'b0; ifa.cmd_write = 1'b0; ifa.cmd_addr = '0; ifa.cmd_len = '0;
        ifa.wdata = 8'h00; ifa.wdata_valid = 1'b0;
        ifb.cmd_valid = 1'b0; ifb.cmd_write = 1'b0; ifb.cmd_addr = '0; ifb.cmd_len = '0;
        ifb.wdata = 8'h00; ifb.wdata_valid = 1'b0;
    endtask

    task automatic run_vec(input int n, input vec_t v);
        int cyc, strobes, ready_cnt, stall_cnt, widx, run, min_run, max_run, nbytes;
        int excl_err, drv_err, cen_err, stab_err, data_err, addr_err, rv_cnt, done_cyc;
        logic prev_low, prev_ready, got_done, strobe_low;
        logic [2:0] done_bus;
        logic [19:0] a, first_addr, last_addr, stab_addr;
        logic [7:0] e, first_data, last_data, stab_data;

        nbytes = int'(v.len) + 1;
        exp_q.delete();
        for (int k = 0; k < nbytes; k++) begin
            a = v.addr + 20'(k);
            exp_q.push_back(v.wr ? 8'(v.wbase + 8'(k)) : 8'(a[7:0] ^ 8'h5A));
        end
        cyc = 0; strobes = 0; ready_cnt = 0; stall_cnt = 0; widx = 0; run = 0;
        min_run = 999; max_run = 0; excl_err = 0; drv_err = 0; cen_err = 0; stab_err = 0;
        data_err = 0; addr_err = 0; rv_cnt = 0; done_cyc = 0; done_bus = 3'b000;
        prev_low = 1'b0; prev_ready = 1'b0; got_done = 1'b0;
        first_addr = '0; last_addr = '0; stab_addr = '0;
        first_data = 8'h00; last_data = 8'h00; stab_data = 8'h00;

        @(negedge clk);
        ifa.cmd_valid = 1'b1; ifa.cmd_write = v.wr; ifa.cmd_addr = v.addr; ifa.cmd_len = v.len;
        ifa.wdata_valid = v.wr; ifa.wdata = v.wbase;

        while (!got_done && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            ifa.cmd_valid = 1'b0;
            if (prev_ready && ifa.wdata_valid) widx++;

            if (ifa.wdata_ready) ready_cnt++;
            if (!ifa.usb_rdn && !ifa.usb_wrn) excl_err++;
            if (v.wr && !ifa.usb_rdn) excl_err++;
            if (!v.wr && !ifa.usb_wrn) excl_err++;
            if (!v.wr && ifa.usb_drive_en) drv_err++;
            if (v.wr && !ifa.usb_wrn && !ifa.usb_drive_en) drv_err++;

            strobe_low = v.wr ? !ifa.usb_wrn : !ifa.usb_rdn;
            if (strobe_low && !prev_low) begin
                strobes++;
                if (ifa.usb_addr !== 20'(v.addr + 20'(strobes - 1))) addr_err++;
                if (strobes == 1) first_addr = ifa.usb_addr;
                last_addr = ifa.usb_addr;
                stab_addr = ifa.usb_addr;
                stab_data = ifa.usb_dout;
                run = 1;
                if (v.wr) begin
                    if (strobes == 1) first_data = ifa.usb_dout;
                    last_data = ifa.usb_dout;
                    if (exp_q.size() == 0) data_err++;
                    else begin
                        e = exp_q.pop_front();
                        if (ifa.usb_dout !== e) data_err++;
                    end
                end
            end else if (strobe_low) begin
                run++;
                if (ifa.usb_addr !== stab_addr) stab_err++;
                if (v.wr && ifa.usb_dout !== stab_data) stab_err++;
            end
            if (!strobe_low && prev_low) begin
                if (run < min_run) min_run = run;
                if (run > max_run) max_run = run;
            end
            prev_low = strobe_low;

            if (ifa.rdata_valid) begin
                rv_cnt++;
                if (v.wr) data_err++;
                else begin
                    if (rv_cnt == 1) first_data = ifa.rdata;
                    last_data = ifa.rdata;
                    if (exp_q.size() == 0) data_err++;
                    else begin
                        e = exp_q.pop_front();
                        if (ifa.rdata !== e) data_err++;
                    end
                end
            end

            if (ifa.done) begin
                got_done = 1'b1;
                done_cyc = cyc;
                done_bus = {ifa.usb_cen, ifa.usb_drive_en, ifa.cmd_ready};
            end else if (ifa.usb_cen) begin
                cen_err++;
            end

            prev_ready = ifa.wdata_ready;
            if (v.wr && widx < nbytes) begin
                if (widx == 1 && stall_cnt < v.stall && ifa.wdata_ready) begin
                    ifa.wdata_valid = 1'b0;
                    stall_cnt++;
                end else begin
                    ifa.wdata_valid = 1'b1;
                    ifa.wdata = 8'(v.wbase + 8'(widx));
                end
            end else begin
                ifa.wdata_valid = 1'b0;
            end
        end

        chk($sformatf("v%0d_done_seen", n), got_done, 1'b1);
        chk($sformatf("v%0d_strobes", n), strobes, v.exp_bytes);
        chk($sformatf("v%0d_first_addr", n), first_addr, v.addr);
        chk($sformatf("v%0d_last_addr", n), last_addr, v.exp_last_addr);
        chk($sformatf("v%0d_addr_step_err", n), addr_err, 0);
        chk($sformatf("v%0d_first_data", n), first_data, v.exp_first);
        chk($sformatf("v%0d_last_data", n), last_data, v.exp_last);
        chk($sformatf("v%0d_data_err", n), data_err, 0);
        chk($sformatf("v%0d_exp_q_left", n), exp_q.size(), 0);
        chk($sformatf("v%0d_cycles", n), done_cyc, v.exp_cycles);
        chk($sformatf("v%0d_strobe_min", n), min_run, 2);
        chk($sformatf("v%0d_strobe_max", n), max_run, 2);
        chk($sformatf("v%0d_wdata_ready_cycles", n), ready_cnt, v.exp_ready);
        chk($sformatf("v%0d_rdata_valid_cnt", n), rv_cnt, v.wr ? 0 : v.exp_bytes);
        chk($sformatf("v%0d_strobe_excl_err", n), excl_err, 0);
        chk($sformatf("v%0d_drive_en_err", n), drv_err, 0);
        chk($sformatf("v%0d_cen_high_mid_burst", n), cen_err, 0);
        chk($sformatf("v%0d_strobe_stability_err", n), stab_err, 0);
        chk($sformatf("v%0d_cen_drv_rdy_at_done", n), done_bus, 3'b101);
        @(negedge clk);
        chk($sformatf("v%0d_done_one_cycle", n), ifa.done, 1'b0);
        chk($sformatf("v%0d_cmd_ready_after", n), ifa.cmd_ready, 1'b1);
    endtask

    task automatic reset_mid_strobe();
        logic found;
        int done_cnt, cen_low;
        found = 1'b0;
        @(negedge clk);
        ifa.cmd_valid = 1'b1; ifa.cmd_write = 1'b1; ifa.cmd_addr = 20'h00055; ifa.cmd_len = 7'd3;
        ifa.wdata_valid = 1'b1; ifa.wdata = 8'h77;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            ifa.cmd_valid = 1'b0;
            if (!ifa.usb_wrn) found = 1'b1;
        end
        chk("rst_reached_strobe", found, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_wrn", ifa.usb_wrn, 1'b1);
        chk("rst_cen", ifa.usb_cen, 1'b1);
        chk("rst_drive_en", ifa.usb_drive_en, 1'b0);
        chk("rst_cmd_ready", ifa.cmd_ready, 1'b1);
        chk("rst_done", ifa.done, 1'b0);
        chk("rst_state", ifa.dbg_state, 3'd0);
        reset = 1'b0;
        ifa.wdata_valid = 1'b0;
        done_cnt = 0; cen_low = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (ifa.done) done_cnt++;
            if (!ifa.usb_cen) cen_low++;
        end
        chk("rst_no_done_after", done_cnt, 0);
        chk("rst_bus_stays_idle", cen_low, 0);
    endtask

    task automatic slow_timing_read();
        int rdn_cyc[$];
        int rv_cyc[$];
        logic [7:0] rv_dat[$];
        int done_cyc, cen_high;
        done_cyc = 0; cen_high = 0;
        @(negedge clk);
        ifb.cmd_valid = 1'b1; ifb.cmd_write = 1'b0; ifb.cmd_addr = 20'h00077; ifb.cmd_len = 7'd1;
        for (int c = 1; c <= 40 && done_cyc == 0; c++) begin
            @(negedge clk);
            ifb.cmd_valid = 1'b0;
            if (!ifb.usb_rdn) rdn_cyc.push_back(c);
            if (ifb.rdata_valid) begin
                rv_cyc.push_back(c);
                rv_dat.push_back(ifb.rdata);
            end
            if (ifb.done) done_cyc = c;
            else if (ifb.usb_cen) cen_high++;
            if (ifb.usb_drive_en || !ifb.usb_wrn) cen_high++;
        end
        chk("slow_rdn_low_count", rdn_cyc.size(), 2);
        chk("slow_rv_count", rv_cyc.size(), 2);
        if (rdn_cyc.size() == 2 && rv_cyc.size() == 2) begin
            chk("slow_rdn_cycle0", rdn_cyc[0], 4);
            chk("slow_rdn_cycle1", rdn_cyc[1], 10);
            chk("slow_rv_cycle0", rv_cyc[0], 5);
            chk("slow_rv_cycle1", rv_cyc[1], 11);
            chk("slow_rdata0", rv_dat[0], 8'h2D);
            chk("slow_rdata1", rv_dat[1], 8'h22);
        end
        chk("slow_done_cycle", done_cyc, 13);
        chk("slow_bus_misbehave", cen_high, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1);
    end

    initial begin
        // wr, addr, len, stall, wbase, bytes, last_addr, first, last, cycles, ready_cycles
        vecs[0] = '{1'b1, 20'h00123, 7'd0,   0,  8'hA5, 1,   20'h00123, 8'hA5, 8'hA5, 6,   1};
        vecs[1] = '{1'b0, 20'h00040, 7'd3,   0,  8'h00, 4,   20'h00043, 8'h1A, 8'h19, 17,  0};
        vecs[2] = '{1'b1, 20'h00300, 7'd1,   10, 8'h3C, 2,   20'h00301, 8'h3C, 8'h3D, 21,  12};
        vecs[3] = '{1'b0, 20'hFFFFF, 7'd1,   0,  8'h00, 2,   20'h00000, 8'hA5, 8'h5A, 9,   0};
        vecs[4] = '{1'b1, 20'h00200, 7'd2,   0,  8'h10, 3,   20'h00202, 8'h10, 8'h12, 16,  3};
        vecs[5] = '{1'b0, 20'h00100, 7'd127, 0,  8'h00, 128, 20'h0017F, 8'h5A, 8'h25, 513, 0};

        idle_inputs();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_cen", ifa.usb_cen, 1'b1);
        chk("reset_rdn", ifa.usb_rdn, 1'b1);
        chk("reset_wrn", ifa.usb_wrn, 1'b1);
        chk("reset_drive_en", ifa.usb_drive_en, 1'b0);
        chk("reset_addr", ifa.usb_addr, 20'h0);
        chk("reset_dout", ifa.usb_dout, 8'h00);
        chk("reset_rdata", ifa.rdata, 8'h00);
        chk("reset_pulses", {ifa.rdata_valid, ifa.done, ifa.wdata_ready}, 3'b000);
        chk("reset_cmd_ready", ifa.cmd_ready, 1'b1);
        chk("reset_state", ifa.dbg_state, 3'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            run_vec(i, vecs[i]);
            repeat (2) @(negedge clk);
        end

        slow_timing_read();
        repeat (2) @(negedge clk);
        reset_mid_strobe();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/usb_bus_master.md
Name: usb_bus_master

Overview:
- Bus initiator for the parallel USB register bus (address, bidirectional 8-bit data, nRD, nWR, nCE) that the FPGA register front-end responds to.
- Converts a simple command/stream interface into correctly timed read and write bus cycles, including auto-incrementing bursts.
- Used for on-board loopback self-test of the register front-end, and as the host-side driver in simulation benches.
- Sits between a test sequencer and the pins or bus model.

Parameters:
- pADDR_WIDTH, 20, bus address width.
- pBYTECNT_SIZE, 7, width of the burst length field.
- pSETUP_CYCLES, 1, cycles the address (and write data) is valid with nCE low before the strobe asserts; legal range 1..15.
- pSTROBE_CYCLES, 2, cycles nRD/nWR is held low; legal range 1..15.
- pHOLD_CYCLES, 1, cycles after the strobe rises before the address or data changes; legal range 1..15.

Ports:
- clk  in  1  single clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE.
- cmd_write  in  1  1 = write burst, 0 = read burst.
- cmd_addr  in  pADDR_WIDTH  start address.
- cmd_len  in  pBYTECNT_SIZE  burst length in bytes, minus 1.
- wdata  in  8  write byte.
- wdata_valid  in  1  write byte available.
- wdata_ready  out  1  high only in WDATA state.
- rdata  out  8  read byte.
- rdata_valid  out  1  one-cycle pulse per read byte.
- done  out  1  one-cycle pulse at burst completion.
- usb_addr  out  pADDR_WIDTH  bus address.
- usb_dout  out  8  data driven onto the bus.
- usb_din  in  8  data sampled from the bus.
- usb_drive_en  out  1  tristate enable for usb_dout.
- usb_cen  out  1  active-low chip enable.
- usb_rdn  out  1  active-low read strobe.
- usb_wrn  out  1  active-low write strobe.

Behaviour:
- All outputs are registered.
- Reset values:
  - usb_cen = usb_rdn = usb_wrn = 1.
  - usb_drive_en = 0; usb_addr = 0; usb_dout = 0; rdata = 0.
  - rdata_valid = done = wdata_ready = 0; cmd_ready = 1.
  - State = IDLE.
- States: IDLE, WDATA, SETUP, STROBE, HOLD.
- IDLE:
  - Bus is idle (cen, rdn, wrn high; drive_en low).
  - On cmd_valid & cmd_ready: latch address into usb_addr, latch cmd_write, load the remaining-bytes counter with cmd_len, drop usb_cen.
  - Next state is WDATA for a write, SETUP for a read.
  - cmd_* inputs are ignored outside IDLE.
- WDATA:
  - wdata_ready = 1; usb_cen stays low; strobes stay high.
  - On wdata_valid: usb_dout <= wdata, usb_drive_en <= 1, go to SETUP.
  - Without wdata_valid, stall indefinitely with no strobe.
- SETUP:
  - Hold for pSETUP_CYCLES cycles, then go to STROBE.
  - The strobe (rdn for a read, wrn for a write) falls on the edge of the SETUP→STROBE transition.
- STROBE:
  - Strobe low for exactly pSTROBE_CYCLES cycles; address and data stable.
  - Read: usb_din is captured into rdata on the last STROBE cycle; rdata_valid pulses in the first HOLD cycle.
  - The strobe rises on entry to HOLD.
- HOLD:
  - Lasts pHOLD_CYCLES cycles; usb_cen stays low; drive_en and address are held.
  - At HOLD end, if remaining ≠ 0:
    - usb_addr <= usb_addr + 1 (wraps modulo 2^pADDR_WIDTH); remaining decrements.
    - Next state is WDATA (write) or SETUP (read).
    - usb_cen stays low across the whole burst; drive_en drops while in WDATA.
  - At HOLD end, if remaining = 0:
    - usb_cen <= 1, usb_drive_en <= 0, done pulses for one cycle, go to IDLE.
    - cmd_ready returns high in that same cycle.
- Exclusivity: usb_rdn and usb_wrn are never low simultaneously. usb_drive_en is never high during a read burst.
- Byte timing: one byte takes pSETUP + pSTROBE + pHOLD cycles, plus 1 WDATA cycle minimum for writes.
- Burst length: cmd_len = 2^pBYTECNT_SIZE − 1 gives the maximum burst of 128 bytes.
- Reset mid-burst: on the next edge the bus is released (strobes high, cen high, drive_en low), no done pulse, no rdata_valid pulse, state returns to IDLE.

Test Plan:
- Single write with defaults: cmd_write=1, addr=0x00123, len=0, wdata=0xA5 supplied immediately.
  - wdata_ready is high 1 cycle.
  - usb_wrn is low for exactly 2 cycles with usb_addr=0x00123 and usb_dout=0xA5 stable, drive_en=1.
  - done pulses 4 cycles after WDATA exits; cmd_ready then rises.
- Read burst: addr=0x00040, len=3, bus model returns addr[7:0]^0x5A.
  - 4 rdata_valid pulses with rdata=0x1A, 0x1B, 0x18, 0x19.
  - usb_addr steps 0x40..0x43; usb_cen stays low throughout; drive_en stays 0; usb_wrn stays 1.
- Write stall: write with len=1, wdata_valid withheld 10 cycles before the second byte.
  - usb_wrn stays high through the stall; usb_cen stays low.
  - Second strobe occurs at addr+1 with the new byte.
- Address wrap: read at addr=0xFFFFF, len=1 → second access at usb_addr=0x00000.
- Reset mid-strobe: assert reset during STROBE of a write.
  - Next cycle: usb_wrn=1, usb_cen=1, drive_en=0, cmd_ready=1.
  - No done pulse.
- Timing parameters: set pSETUP=3, pSTROBE=1, pHOLD=2.
  - Read byte spans 6 cycles.
  - rdn is low exactly 1 cycle; rdata is captured in that cycle.
